// File: rtl/tft_pkg.sv
// ---------------------------------------------------------------------------
// tft_pkg
// Shared definitions for the TFT panel path: transmitter state encoding,
// data/command flag values, default serial timing and the panel command
// opcodes used by the window/command sequencer.
// ---------------------------------------------------------------------------
package tft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tft_state_t;

    localparam logic TFT_DC_CMD  = 1'b0;
    localparam logic TFT_DC_DATA = 1'b1;

    localparam int TFT_CLK_DIV_DEFAULT = 4;
    localparam int TFT_CS_GAP_DEFAULT  = 1;

    localparam logic [7:0] TFT_CMD_CASET = 8'h2A;
    localparam logic [7:0] TFT_CMD_RASET = 8'h2B;
    localparam logic [7:0] TFT_CMD_RAMWR = 8'h2C;

endpackage : tft_pkg

// File: rtl/tft_spi_clk_div.sv
// ---------------------------------------------------------------------------
// tft_spi_clk_div
// Half-period strobe generator. Counts 0..DIV-1 while not cleared and pulses
// o_strobe for one clk cycle on the last count, then starts again from 0.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   i_clr    holds the counter at 0 (and suppresses the strobe)
//   o_strobe one-cycle pulse every DIV cycles while i_clr is low
// ---------------------------------------------------------------------------
module tft_spi_clk_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_strobe
);

    localparam int CNT_W = $clog2(DIV + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap   = (r_cnt == CNT_W'(DIV - 1));
    assign o_strobe = w_wrap & ~i_clr;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : tft_spi_clk_div

// File: rtl/tft_spi_tx.sv
// ---------------------------------------------------------------------------
// tft_spi_tx
// Byte transmitter for the TFT panel's 4-wire SPI link (mode 0, MSB first).
// A byte is accepted when tft_transmit is high in IDLE; it is shifted out
// over 16 SCK half-periods with spi_cs low, followed by a chip-select-high
// gap of CS_GAP half-periods. busy covers the whole shift + gap window.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   tft_data      byte to send (sampled on the accept cycle only)
//   tft_dc        0 = command, 1 = data (sampled with tft_data)
//   tft_transmit  single-cycle request, ignored while busy
//   busy          high while a byte is in flight
//   spi_sck       serial clock, idles low
//   spi_mosi      serial data, MSB first
//   spi_cs        active-low chip select
//   spi_dc        data/command line, held from accept to next accept
// ---------------------------------------------------------------------------
module tft_spi_tx
    import tft_pkg::*;
#(
    parameter int CLK_DIV = TFT_CLK_DIV_DEFAULT,
    parameter int CS_GAP  = TFT_CS_GAP_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tft_data,
    input  logic       tft_dc,
    input  logic       tft_transmit,
    output logic       busy,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       spi_cs,
    output logic       spi_dc
);

    localparam int GAP_W = $clog2(CS_GAP * CLK_DIV + 1);

    tft_state_t       r_state,   w_state_nxt;
    logic             r_busy,    w_busy_nxt;
    logic             r_sck,     w_sck_nxt;
    logic             r_mosi,    w_mosi_nxt;
    logic             r_cs,      w_cs_nxt;
    logic             r_dc,      w_dc_nxt;
    // Bit 7 goes straight to MOSI on accept, so only bits 6..0 are held.
    logic [6:0]       r_shreg,   w_shreg_nxt;
    // Bit 3 is the overflow bit: it sets on the 8th falling SCK edge.
    logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;

    logic             w_strobe;
    logic             w_div_clr;
    logic [3:0]       w_bit_inc;

    // The divider is held at 0 in IDLE so the first SCK half-period after an
    // accept is a full CLK_DIV cycles long (MOSI setup before the first rise).
    assign w_div_clr = (r_state == ST_IDLE);
    assign w_bit_inc = r_bit_cnt + 4'd1;

    tft_spi_clk_div #(
        .DIV      (CLK_DIV)
    ) u_clk_div (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_div_clr),
        .o_strobe (w_strobe)
    );

    // NOTE: every signal assigned here gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = r_busy;
        w_sck_nxt     = r_sck;
        w_mosi_nxt    = r_mosi;
        w_cs_nxt      = r_cs;
        w_dc_nxt      = r_dc;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;

        unique case (r_state)
            ST_IDLE: begin
                if (tft_transmit) begin
                    w_state_nxt   = ST_SHIFT;
                    w_busy_nxt    = 1'b1;
                    w_cs_nxt      = 1'b0;
                    w_sck_nxt     = 1'b0;
                    w_mosi_nxt    = tft_data[7];
                    w_shreg_nxt   = tft_data[6:0];
                    w_dc_nxt      = tft_dc;
                    w_bit_cnt_nxt = '0;
                    w_gap_cnt_nxt = '0;
                end
            end

            ST_SHIFT: begin
                if (w_strobe) begin
                    w_sck_nxt = ~r_sck;
                    // SCK high -> low: advance to the next bit.
                    if (r_sck) begin
                        w_bit_cnt_nxt = w_bit_inc;
                        w_mosi_nxt    = r_shreg[6];
                        w_shreg_nxt   = {r_shreg[5:0], 1'b0};
                        if (w_bit_inc[3]) begin
                            w_state_nxt = ST_GAP;
                            w_cs_nxt    = 1'b1;
                            w_mosi_nxt  = 1'b0;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (w_strobe) begin
                    if (r_gap_cnt == GAP_W'(CS_GAP - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_cs_nxt    = 1'b1;
                w_sck_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs      <= 1'b1;
            r_dc      <= 1'b0;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_sck     <= w_sck_nxt;
            r_mosi    <= w_mosi_nxt;
            r_cs      <= w_cs_nxt;
            r_dc      <= w_dc_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    assign busy     = r_busy;
    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;
    assign spi_cs   = r_cs;
    assign spi_dc   = r_dc;

endmodule : tft_spi_tx

// File: tb/tb_tft_spi_tx.sv
// ---------------------------------------------------------------------------
// tb_tft_spi_tx
// Directed bench for tft_spi_tx. Two instances are used: one at CLK_DIV=2
// and one at CLK_DIV=1 (both CS_GAP=1). A small panel model watches the
// selected instance's SPI pins and collects {dc, byte} for every complete
// chip-select frame, counting incomplete frames and protocol violations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tft_spi_tx;
    import tft_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance with CLK_DIV=2
    logic [7:0] d2_data = '0;
    logic       d2_dc = 1'b0, d2_tx = 1'b0;
    logic       d2_busy, d2_sck, d2_mosi, d2_cs, d2_spi_dc;
    // Instance with CLK_DIV=1
    logic [7:0] d1_data = '0;
    logic       d1_dc = 1'b0, d1_tx = 1'b0;
    logic       d1_busy, d1_sck, d1_mosi, d1_cs, d1_spi_dc;

    tft_spi_tx #(.CLK_DIV(2), .CS_GAP(1)) u_dut_d2 (
        .clk(clk), .rst(rst), .tft_data(d2_data), .tft_dc(d2_dc),
        .tft_transmit(d2_tx), .busy(d2_busy), .spi_sck(d2_sck),
        .spi_mosi(d2_mosi), .spi_cs(d2_cs), .spi_dc(d2_spi_dc)
    );

    tft_spi_tx #(.CLK_DIV(1), .CS_GAP(1)) u_dut_d1 (
        .clk(clk), .rst(rst), .tft_data(d1_data), .tft_dc(d1_dc),
        .tft_transmit(d1_tx), .busy(d1_busy), .spi_sck(d1_sck),
        .spi_mosi(d1_mosi), .spi_cs(d1_cs), .spi_dc(d1_spi_dc)
    );

    // Selected instance (0 = CLK_DIV=2, 1 = CLK_DIV=1)
    logic sel = 1'b0;
    logic m_busy, m_sck, m_mosi, m_cs, m_dc;
    assign m_busy = sel ? d1_busy   : d2_busy;
    assign m_sck  = sel ? d1_sck    : d2_sck;
    assign m_mosi = sel ? d1_mosi   : d2_mosi;
    assign m_cs   = sel ? d1_cs     : d2_cs;
    assign m_dc   = sel ? d1_spi_dc : d2_spi_dc;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- panel model (samples on falling clk) ----------------
    logic [7:0] mdl_sh;
    int         mdl_bits, mdl_rises, mdl_incomplete, mdl_dc_bad, mdl_mosi_bad, mdl_hi_run;
    bit         mdl_frame_seen, mdl_prev_sck, mdl_prev_cs, mdl_prev_mosi, mdl_dc0;
    logic [8:0] rxq[$];
    int         gapq[$];

    task automatic mdl_clear();
        rxq.delete();
        gapq.delete();
        mdl_sh = '0; mdl_bits = 0; mdl_rises = 0; mdl_incomplete = 0;
        mdl_dc_bad = 0; mdl_mosi_bad = 0; mdl_hi_run = 0;
        mdl_frame_seen = 0; mdl_prev_sck = 0; mdl_prev_cs = 1; mdl_prev_mosi = 0; mdl_dc0 = 0;
    endtask

    always @(negedge clk) begin
        if (!rst || !mdl_prev_cs) begin
            if (!m_cs) begin
                if (mdl_prev_cs) begin
                    if (mdl_frame_seen) gapq.push_back(mdl_hi_run);
                    mdl_bits = 0;
                    mdl_dc0  = m_dc;
                end
                if (m_dc !== mdl_dc0) mdl_dc_bad++;
                if (m_sck && !mdl_prev_sck) begin
                    mdl_sh = {mdl_sh[6:0], m_mosi};
                    mdl_bits++;
                    mdl_rises++;
                end
                if (m_sck && mdl_prev_sck && (m_mosi !== mdl_prev_mosi)) mdl_mosi_bad++;
            end else begin
                if (!mdl_prev_cs) begin
                    if (mdl_bits == 8) rxq.push_back({mdl_dc0, mdl_sh});
                    else mdl_incomplete++;
                    mdl_frame_seen = 1;
                    mdl_hi_run = 0;
                end
                mdl_hi_run++;
            end
        end
        mdl_prev_sck  = m_sck;
        mdl_prev_cs   = m_cs;
        mdl_prev_mosi = m_mosi;
    end

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge: request now, accepted at the next rising edge.
    // Returns at the falling edge just after the accept edge.
    task automatic send_now(input logic [7:0] data, input logic dc);
        if (sel) begin d1_data = data; d1_dc = dc; d1_tx = 1'b1; end
        else     begin d2_data = data; d2_dc = dc; d2_tx = 1'b1; end
        @(negedge clk);
        d1_tx = 1'b0;
        d2_tx = 1'b0;
    endtask

    // Waits (bounded) until busy reads 0; counts busy and cs-low cycles seen.
    task automatic wait_idle(output int busy_n, output int cs_low_n);
        busy_n = 0;
        cs_low_n = 0;
        for (int i = 0; i < 500; i++) begin
            if (!m_busy) break;
            busy_n++;
            if (!m_cs) cs_low_n++;
            @(negedge clk);
        end
        if (m_busy) check("idle_timeout", 32'(m_busy), 32'd0);
    endtask

    int busy_n, cs_low_n, busy_cnt, rises, sck_hi;
    logic prev_sck;
    logic [7:0] prod_bytes [3];

    initial begin
        prod_bytes[0] = 8'h00; prod_bytes[1] = 8'hFF; prod_bytes[2] = 8'h3C;
        mdl_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ---- reset / idle: all outputs at reset values for 20 cycles ----
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_d2 {busy,sck,mosi,cs,dc}",
                  32'({d2_busy, d2_sck, d2_mosi, d2_cs, d2_spi_dc}), 32'b00010);
        end
        check("idle_d1 {busy,sck,mosi,cs,dc}",
              32'({d1_busy, d1_sck, d1_mosi, d1_cs, d1_spi_dc}), 32'b00010);

        // ---- CLK_DIV=2: 0xA5 as data ----
        @(posedge clk); mdl_clear(); sel = 1'b0;
        @(negedge clk);
        send_now(8'hA5, TFT_DC_DATA);
        check("a5 mosi_on_accept", 32'(m_mosi), 32'd1);
        check("a5 cs_on_accept", 32'(m_cs), 32'd0);
        wait_idle(busy_n, cs_low_n);
        check("a5 busy_cycles", 32'(busy_n), 32'd34);
        check("a5 cs_low_cycles", 32'(cs_low_n), 32'd32);
        repeat (3) @(negedge clk);
        check("a5 rx_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) check("a5 rx_byte", 32'(rxq[0]), 32'h1A5);
        check("a5 sck_rises", 32'(mdl_rises), 32'd8);
        check("a5 dc_changes", 32'(mdl_dc_bad), 32'd0);
        check("a5 mosi_unstable_high", 32'(mdl_mosi_bad), 32'd0);
        check("a5 dc_held_idle", 32'(m_dc), 32'd1);

        // ---- CLK_DIV=2: 0x2A command with ignored 0xFF requests ----
        @(posedge clk); mdl_clear();
        @(negedge clk);
        send_now(8'h2A, TFT_DC_CMD);
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (m_busy) busy_cnt++;
            d2_data = 8'hFF;
            d2_dc   = TFT_DC_DATA;
            d2_tx   = (k == 1 || k == 10 || k == 33);
            @(negedge clk);
        end
        d2_tx = 1'b0;
        repeat (3) @(negedge clk);
        check("2a busy_cycles", 32'(busy_cnt), 32'd34);
        check("2a still_idle", 32'(m_busy), 32'd0);
        check("2a rx_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) check("2a rx_byte", 32'(rxq[0]), 32'h02A);
        check("2a dc_held_idle", 32'(m_dc), 32'd0);

        // ---- CLK_DIV=1: back-to-back producer 0x00, 0xFF, 0x3C ----
        @(posedge clk); mdl_clear(); sel = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            wait_idle(busy_n, cs_low_n);
            if (b > 0) check("b2b busy_cycles", 32'(busy_n), 32'd17);
            send_now(prod_bytes[b], TFT_DC_DATA);
        end
        wait_idle(busy_n, cs_low_n);
        repeat (3) @(negedge clk);
        check("b2b rx_count", 32'(rxq.size()), 32'd3);
        for (int b = 0; b < 3; b++)
            if (b < rxq.size()) check("b2b rx_byte", 32'(rxq[b]), 32'({1'b1, prod_bytes[b]}));
        check("b2b gap_count", 32'(gapq.size()), 32'd2);
        for (int g = 0; g < 2; g++)
            if (g < gapq.size()) check("b2b cs_high_gap", 32'(gapq[g]), 32'd2);
        check("b2b mosi_unstable_high", 32'(mdl_mosi_bad), 32'd0);

        // ---- CLK_DIV=1: reset after 3rd SCK rise of 0x81 ----
        @(posedge clk); mdl_clear();
        @(negedge clk);
        prev_sck = m_sck;
        rises = 0;
        send_now(8'h81, TFT_DC_DATA);
        for (int i = 0; i < 60; i++) begin
            if (m_sck && !prev_sck) rises++;
            prev_sck = m_sck;
            if (rises == 3) break;
            @(negedge clk);
        end
        check("abort third_rise_seen", 32'(rises), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort {busy,sck,mosi,cs}", 32'({m_busy, m_sck, m_mosi, m_cs}), 32'b0001);
        sck_hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_sck) sck_hi++;
        end
        check("abort no_sck_after", 32'(sck_hi), 32'd0);
        check("abort incomplete_flag", 32'(mdl_incomplete), 32'd1);
        check("abort no_data", 32'(rxq.size()), 32'd0);

        // ---- tft_transmit during rst is ignored ----
        rst = 1'b1; d1_data = 8'h77; d1_tx = 1'b1;
        @(negedge clk);
        rst = 1'b0; d1_tx = 1'b0;
        @(negedge clk);
        check("rst_tx {busy,cs}", 32'({m_busy, m_cs}), 32'b01);

        // ---- 0x55 after the aborted byte ----
        @(posedge clk); mdl_clear();
        @(negedge clk);
        send_now(8'h55, TFT_DC_CMD);
        wait_idle(busy_n, cs_low_n);
        check("55 busy_cycles", 32'(busy_n), 32'd17);
        repeat (3) @(negedge clk);
        check("55 rx_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) check("55 rx_byte", 32'(rxq[0]), 32'h055);
        check("55 incomplete_flag", 32'(mdl_incomplete), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_tft_spi_tx
